// File: rtl/ga_pkg.sv
// ga_pkg: constants and types shared by the genetic-algorithm blocks.
//   DATA_W       width of one weight (1 integer + 5 fraction bits)
//   M_MAX        maximum number of weights per chromosome
//   M_MAX_W      width of a weight count (0..M_MAX)
//   M_IDX_MAX_W  width of a weight index (0..M_MAX-1)
//   CHROM_MAX_W  chromosome width; weight i sits at [i*DATA_W +: DATA_W]
//   RAND_W       random word width: {r_hi, r_lo}, each M_IDX_MAX_W bits
package ga_pkg;

  localparam int DATA_W      = 6;
  localparam int M_MAX       = 32;
  localparam int M_MAX_W     = $clog2(M_MAX + 1);
  localparam int M_IDX_MAX_W = $clog2(M_MAX);
  localparam int CHROM_MAX_W = DATA_W * M_MAX;
  localparam int RAND_W      = 2 * M_IDX_MAX_W;

  typedef enum logic [1:0] {MUT_IDLE, MUT_MUTATE, MUT_OUT} ga_mut_state_t;

  typedef logic [DATA_W-1:0] ga_weight_t;

  // Weight counts above M_MAX behave exactly like M_MAX.
  function automatic logic [M_MAX_W-1:0] clamp_m(input logic [M_MAX_W-1:0] m);
    if (m > M_MAX_W'(M_MAX)) return M_MAX_W'(M_MAX);
    return m;
  endfunction

endpackage

// File: rtl/ga_mut_weight_flip.sv
// ga_mut_weight_flip: combinational single-weight mutation.
//   weight      in   weight to mutate
//   r_hi        in   random value compared against thr
//   r_lo        in   random value selecting the bit (r_lo % DATA_W)
//   thr         in   mutation threshold, 0 = never, M_MAX = always
//   new_weight  out  weight with the selected bit inverted when flip is set
//   flip        out  r_hi < thr
module ga_mut_weight_flip
  import ga_pkg::*;
(
  input  ga_weight_t             weight,
  input  logic [M_IDX_MAX_W-1:0] r_hi,
  input  logic [M_IDX_MAX_W-1:0] r_lo,
  input  logic [M_IDX_MAX_W:0]   thr,
  output ga_weight_t             new_weight,
  output logic                   flip
);

  logic [M_IDX_MAX_W-1:0] bit_sel;

  assign bit_sel = r_lo % M_IDX_MAX_W'(DATA_W);

  always_comb begin
    flip       = ({1'b0, r_hi} < thr);
    new_weight = weight;
    if (flip) new_weight = weight ^ (ga_weight_t'(1) << bit_sel);
  end

endmodule

// File: rtl/ga_mutation.sv
// ga_mutation: receives a child chromosome from ga_crossover, walks weights
// 0..m-1 one per cycle, optionally flipping one bit per weight, then offers
// the mutated chromosome downstream.
//   clk, rst       clock; asynchronous active-high reset
//   sw_rst         synchronous soft reset, same effect as rst
//   cnfg_m         active weights (clamped to M_MAX), sampled at accept
//   cnfg_mut_thr   mutation threshold, sampled at accept
//   rand_data      fresh random word each cycle, {r_hi, r_lo}
//   child_valid/child_ack/child   input handshake and chromosome
//   mut_valid/mut_ack/mut_child   output handshake and chromosome
//   mut_flip_cnt   flipped-weight count (only with GA_MUTATION_STATS_EN)
//   dbg_state      current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ack are
// both high; valid and data stay stable until that edge. child_ack is a
// combinational response to child_valid while IDLE.
// Optional feature macro: GA_MUTATION_STATS_EN.
module ga_mutation
  import ga_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst,
  input  logic [M_MAX_W-1:0]     cnfg_m,
  input  logic [M_IDX_MAX_W:0]   cnfg_mut_thr,
  input  logic [RAND_W-1:0]      rand_data,
  input  logic                   child_valid,
  input  logic [CHROM_MAX_W-1:0] child,
  output logic                   child_ack,
  output logic                   mut_valid,
  output logic [CHROM_MAX_W-1:0] mut_child,
  input  logic                   mut_ack,
`ifdef GA_MUTATION_STATS_EN
  output logic [M_MAX_W-1:0]     mut_flip_cnt,
`endif
  output ga_mut_state_t          dbg_state
);

  ga_mut_state_t            state, state_nxt;
  logic [M_IDX_MAX_W-1:0]   idx;
  logic [CHROM_MAX_W-1:0]   mut_buf;
  logic [M_MAX_W-1:0]       m_q;
  logic [M_IDX_MAX_W:0]     thr_q;
  logic [M_MAX_W-1:0]       m_clamp;
  logic [CHROM_MAX_W-1:0]   child_masked;
  ga_weight_t               cur_w, new_w;
  logic                     flip;
  logic                     accept;
  logic                     last_w;

  assign m_clamp   = clamp_m(cnfg_m);
  assign child_ack = (state == MUT_IDLE) && child_valid && !rst && !sw_rst;
  assign accept    = child_ack;
  assign last_w    = ({1'b0, idx} == (m_q - M_MAX_W'(1)));
  assign mut_valid = (state == MUT_OUT);
  assign mut_child = mut_buf;
  assign dbg_state = state;

  // Inactive weights are zeroed once at capture so the output never carries
  // stale upstream data beyond the active region.
  always_comb begin
    child_masked = '0;
    for (int i = 0; i < M_MAX; i++) begin
      if (M_MAX_W'(i) < m_clamp) child_masked[i*DATA_W +: DATA_W] = child[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    cur_w = '0;
    for (int i = 0; i < M_MAX; i++) begin
      if (idx == M_IDX_MAX_W'(i)) cur_w = mut_buf[i*DATA_W +: DATA_W];
    end
  end

  ga_mut_weight_flip u_flip (
    .weight     (cur_w),
    .r_hi       (rand_data[RAND_W-1:M_IDX_MAX_W]),
    .r_lo       (rand_data[M_IDX_MAX_W-1:0]),
    .thr        (thr_q),
    .new_weight (new_w),
    .flip       (flip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MUT_IDLE;
    else if (sw_rst) state <= MUT_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUT_IDLE:   if (accept) state_nxt = (m_clamp == '0) ? MUT_OUT : MUT_MUTATE;
      MUT_MUTATE: if (last_w) state_nxt = MUT_OUT;
      MUT_OUT:    if (mut_ack) state_nxt = MUT_IDLE;
      default:    state_nxt = MUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      mut_buf <= '0;
      m_q     <= '0;
      thr_q   <= '0;
    end else if (sw_rst) begin
      idx     <= '0;
      mut_buf <= '0;
      m_q     <= '0;
      thr_q   <= '0;
    end else if (state == MUT_IDLE) begin
      if (accept) begin
        idx     <= '0;
        mut_buf <= child_masked;
        m_q     <= m_clamp;
        thr_q   <= cnfg_mut_thr;
      end
    end else if (state == MUT_MUTATE) begin
      for (int i = 0; i < M_MAX; i++) begin
        if (idx == M_IDX_MAX_W'(i)) mut_buf[i*DATA_W +: DATA_W] <= new_w;
      end
      // idx parks on the last weight rather than wrapping.
      if (!last_w) idx <= idx + M_IDX_MAX_W'(1);
    end
  end

`ifdef GA_MUTATION_STATS_EN
  logic [M_MAX_W-1:0] flip_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flip_cnt <= '0;
    else if (sw_rst) flip_cnt <= '0;
    else if (accept) flip_cnt <= '0;
    else if ((state == MUT_MUTATE) && flip) flip_cnt <= flip_cnt + M_MAX_W'(1);
  end

  assign mut_flip_cnt = flip_cnt;
`endif

endmodule

// File: tb/tb_ga_mutation.sv
// tb_ga_mutation: randomized and directed stimulus for ga_mutation with a
// queue-based scoreboard fed by the driver and drained by an output monitor.
module tb_ga_mutation;
  import ga_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sw_rst = 1'b0;
  logic [M_MAX_W-1:0]     cnfg_m = '0;
  logic [M_IDX_MAX_W:0]   cnfg_mut_thr = '0;
  logic [RAND_W-1:0]      rand_data = '0;
  logic                   child_valid = 1'b0;
  logic [CHROM_MAX_W-1:0] child = '0;
  logic                   child_ack;
  logic                   mut_valid;
  logic [CHROM_MAX_W-1:0] mut_child;
  logic                   mut_ack = 1'b0;
  ga_mut_state_t          dbg_state;
`ifdef GA_MUTATION_STATS_EN
  logic [M_MAX_W-1:0]     mut_flip_cnt;
`endif

  ga_mutation dut (
    .clk          (clk),
    .rst          (rst),
    .sw_rst       (sw_rst),
    .cnfg_m       (cnfg_m),
    .cnfg_mut_thr (cnfg_mut_thr),
    .rand_data    (rand_data),
    .child_valid  (child_valid),
    .child        (child),
    .child_ack    (child_ack),
    .mut_valid    (mut_valid),
    .mut_child    (mut_child),
    .mut_ack      (mut_ack),
`ifdef GA_MUTATION_STATS_EN
    .mut_flip_cnt (mut_flip_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard ----------------
  logic [CHROM_MAX_W-1:0] exp_q[$];
  int                     exp_cyc_q[$];
  int                     exp_flip_q[$];
  int checks = 0;
  int errors = 0;
  int ack_mode = 1;  // 0 random, 1 always high, 2 always low

  task automatic chk(input string name, input logic [CHROM_MAX_W-1:0] act, input logic [CHROM_MAX_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (ack_mode == 0) mut_ack = 1'($urandom_range(0, 1));
    else mut_ack = (ack_mode == 1);
  end

  // Monitor: first cycle of each mut_valid pops an expectation; later cycles
  // of the same offer must hold the same data.
  logic                   held = 1'b0;
  logic [CHROM_MAX_W-1:0] last_out = '0;
  initial forever begin
    @(negedge clk);
    #2;
    if (rst || sw_rst) held = 1'b0;
    else if (mut_valid) begin
      if (!held) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mut_valid", 1, 0);
        end else begin
          chk("mut_child", mut_child, exp_q.pop_front());
          chk("latency", CHROM_MAX_W'(cyc), CHROM_MAX_W'(exp_cyc_q.pop_front()));
`ifdef GA_MUTATION_STATS_EN
          chk("flip_cnt", CHROM_MAX_W'(mut_flip_cnt), CHROM_MAX_W'(exp_flip_q.pop_front()));
`else
          void'(exp_flip_q.pop_front());
`endif
        end
        held = 1'b1;
        last_out = mut_child;
      end else begin
        chk("mut_child_stable", mut_child, last_out);
      end
      if (mut_ack) held = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Reference: weight i < m is copied, then bit (r_lo % 6) is inverted when
  // r_hi < thr, using the random word present at the edge that processes it
  // (edge E(i+1) after the accept edge E0); weights >= m read as zero.
  task automatic send(input logic [CHROM_MAX_W-1:0] c, input int m, input int thr,
                      input bit fixed, input logic [RAND_W-1:0] fval);
    logic [RAND_W-1:0]      r[M_MAX];
    logic [CHROM_MAX_W-1:0] exp;
    logic [DATA_W-1:0]      w;
    int mc, nflip, n, rh, rl;
    mc = (m > M_MAX) ? M_MAX : m;
    exp = '0;
    nflip = 0;
    for (int i = 0; i < M_MAX; i++) r[i] = fixed ? fval : RAND_W'($urandom_range(0, 1023));
    for (int i = 0; i < mc; i++) begin
      w  = c[i*DATA_W +: DATA_W];
      rh = int'(r[i]) / 32;
      rl = int'(r[i]) % 32;
      if (rh < thr) begin
        w[rl % DATA_W] = ~w[rl % DATA_W];
        nflip++;
      end
      exp[i*DATA_W +: DATA_W] = w;
    end
    child = c;
    cnfg_m = M_MAX_W'(m);
    cnfg_mut_thr = (M_IDX_MAX_W + 1)'(thr);
    child_valid = 1'b1;
    #1;
    n = 0;
    while (!child_ack && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!child_ack) begin
      chk("accept_timeout", 0, 1);
      child_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 1 + mc);
    exp_flip_q.push_back(nflip);
    @(posedge clk);
    #1;
    child_valid = 1'b0;
    // Mid-chromosome changes must be ignored.
    child = {6{$urandom()}};
    cnfg_m = M_MAX_W'($urandom_range(0, 40));
    cnfg_mut_thr = (M_IDX_MAX_W + 1)'($urandom_range(0, 32));
    for (int k = 0; k < mc; k++) begin
      rand_data = r[k];
      @(posedge clk);
      #1;
    end
    rand_data = RAND_W'($urandom_range(0, 1023));
  endtask

  function automatic logic [CHROM_MAX_W-1:0] ramp7();
    logic [CHROM_MAX_W-1:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    return c;
  endfunction

  // ---------------- main sequence ----------------
  logic [CHROM_MAX_W-1:0] rc;
  int n;

  initial begin
    child_valid = 1'b1;
    #1;
    chk("rst_child_ack", CHROM_MAX_W'(child_ack), 0);
    chk("rst_mut_valid", CHROM_MAX_W'(mut_valid), 0);
    chk("rst_mut_child", mut_child, 0);
    chk("rst_state", CHROM_MAX_W'(dbg_state), CHROM_MAX_W'(MUT_IDLE));
    child_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // thr=0: passes through unchanged
    ack_mode = 1;
    send(ramp7(), 7, 0, 1'b0, '0);
    // thr=32, rand 0: bit0 of every active weight
    send(ramp7(), 7, 32, 1'b1, RAND_W'(0));
    // thr=32, rand 7: bit1 set in zero weights
    send('0, 7, 32, 1'b1, RAND_W'(7));

    // Back-pressure: output held, input refused
    repeat (3) @(posedge clk);
    ack_mode = 2;
    @(negedge clk);
    send($urandom(), 5, 16, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      child_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_child_ack", CHROM_MAX_W'(child_ack), 0);
      chk("bp_mut_valid", CHROM_MAX_W'(mut_valid), 1);
    end
    ack_mode = 1;
    mut_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("post_ack_child_ack", CHROM_MAX_W'(child_ack), 1);
    chk("post_ack_mut_valid", CHROM_MAX_W'(mut_valid), 0);
    child_valid = 1'b0;

    // m=0 and m above M_MAX
    send({6{$urandom()}}, 0, 32, 1'b0, '0);
    send({6{$urandom()}}, 40, 20, 1'b0, '0);
    send({6{$urandom()}}, 32, 32, 1'b0, '0);
    send({6{$urandom()}}, 1, 32, 1'b0, '0);

    // Async reset in MUTATE at idx=3
    repeat (3) @(posedge clk);
    #1;
    child = {6{$urandom()}};
    cnfg_m = 10;
    cnfg_mut_thr = 16;
    child_valid = 1'b1;
    n = 0;
    #1;
    while (!child_ack && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 child_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_state", CHROM_MAX_W'(dbg_state), CHROM_MAX_W'(MUT_MUTATE));
    rst = 1'b1;
    child_valid = 1'b1;
    #1;
    chk("arst_mut_valid", CHROM_MAX_W'(mut_valid), 0);
    chk("arst_mut_child", mut_child, 0);
    chk("arst_child_ack", CHROM_MAX_W'(child_ack), 0);
    chk("arst_state", CHROM_MAX_W'(dbg_state), CHROM_MAX_W'(MUT_IDLE));
    @(posedge clk);
    #1;
    child_valid = 1'b0;
    rst = 1'b0;
    send(ramp7(), 7, 32, 1'b1, RAND_W'(0));

    // Soft reset in MUTATE
    @(negedge clk);
    child = {6{$urandom()}};
    cnfg_m = 12;
    cnfg_mut_thr = 32;
    child_valid = 1'b1;
    n = 0;
    #1;
    while (!child_ack && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 child_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 sw_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("srst_mut_child", mut_child, 0);
    chk("srst_state", CHROM_MAX_W'(dbg_state), CHROM_MAX_W'(MUT_IDLE));
    sw_rst = 1'b0;

    // Random traffic with random back-pressure
    ack_mode = 0;
    for (int t = 0; t < 30; t++) begin
      rc = {6{$urandom()}};
      send(rc, $urandom_range(0, 40), $urandom_range(0, 32), 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ack_mode = 1;

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", CHROM_MAX_W'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
